// File: rtl/ffm_pkg.sv
// ---------------------------------------------------------------------------
// ffm_pkg
// Shared definitions for the LCB memory arbiter slice: arbiter FSM state
// encoding, default parameter values and a counter-width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ffm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_AW         = 10;
    localparam int DEF_DW         = 12;
    localparam int DEF_TIMEOUT    = 1023;
    localparam int DEF_SWAP_GUARD = 8;

    // Number of bits needed to hold any value in 0..max_value (at least 1).
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request found
// when searching upward (with wrap) from start_i.
// Ports:
//   req_i    in  N   request vector
//   start_i  in  IW  index where the search begins
//   pick_o   out IW  index of the winning request
//   valid_o  out 1   at least one request was asserted
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] pick_o,
    output logic          valid_o
);

    // Walk the offsets from farthest to nearest so the request closest to
    // start_i is the last one written and therefore wins.
    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[IW'((int'(start_i) + k) % N)]) begin
                pick_o  = IW'((int'(start_i) + k) % N);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lcb_mem_arbiter
// Arbitrates N_REQ LCB requesters onto one shared group-buffer memory port.
// Round-robin ownership, a hold timeout with sticky error flags and a guard
// window after every ping-pong buffer switch.
// Ports:
//   clk, reset                        clock, async active-high reset
//   busy[N_REQ]                       per-requester memory request
//   wrd_out/wrd_addr/wren             per-requester write port (flattened)
//   old_wrd_addr/old_rd_en            per-requester read port (flattened)
//   swch                              ping-pong buffer selector
//   comm_old_wrd                      read data from shared memory
//   grant[N_REQ]                      one-hot ownership
//   old_wrd                           read data broadcast to requesters
//   comm_wrd_out/addr/wren            shared write port (registered)
//   comm_old_wrd_addr/comm_old_rd_en  shared read port (registered)
//   timeout_err[N_REQ]                sticky timeout flags
// ---------------------------------------------------------------------------
module lcb_mem_arbiter
    import ffm_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int SWAP_GUARD = DEF_SWAP_GUARD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    busy,
    input  logic [N_REQ*DW-1:0] wrd_out,
    input  logic [N_REQ*AW-1:0] wrd_addr,
    input  logic [N_REQ-1:0]    wren,
    input  logic [N_REQ*AW-1:0] old_wrd_addr,
    input  logic [N_REQ-1:0]    old_rd_en,
    input  logic                swch,
    input  logic [DW-1:0]       comm_old_wrd,
    output logic [N_REQ-1:0]    grant,
    output logic [DW-1:0]       old_wrd,
    output logic [DW-1:0]       comm_wrd_out,
    output logic [AW-1:0]       comm_wrd_addr,
    output logic                comm_wren,
    output logic [AW-1:0]       comm_old_wrd_addr,
    output logic                comm_old_rd_en,
    output logic [N_REQ-1:0]    timeout_err
);

    localparam int IW = cnt_width(N_REQ - 1);
    localparam int HW = cnt_width(TIMEOUT);
    localparam int GW = cnt_width(SWAP_GUARD);

    localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(TIMEOUT);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(SWAP_GUARD);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [GW-1:0]       guard_q, guard_d;
    logic                swch_q;
    logic [N_REQ-1:0]    mask_q, mask_d;
    logic [N_REQ-1:0]    err_q, err_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [DW-1:0]       wrd_q, wrd_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic                wren_q, wren_d;
    logic [AW-1:0]       raddr_q, raddr_d;
    logic                rden_q, rden_d;

    logic [IW-1:0]       pick;
    logic                pick_valid;
    logic                swch_edge;
    logic                guard_open;
    logic                own_busy;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req_i   (busy & ~mask_q),
        .start_i (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    assign swch_edge = swch ^ swch_q;
    assign own_busy  = busy[owner_q];

    // The edge cycle itself is the first blocked cycle, so a counter value of
    // 1 already marks the end of the SWAP_GUARD-cycle window.
    assign guard_open = !swch_edge && (guard_q <= GW'(1));

    // Next-state logic: guard countdown, FSM, hold counter, mask/error flags
    // and the owner-selected shared-port values. The port is only captured
    // while the grant continues, so it reads zero outside GRANT.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        err_d   = err_q;
        mask_d  = mask_q & busy;
        grant_d = '0;
        wrd_d   = '0;
        waddr_d = '0;
        wren_d  = 1'b0;
        raddr_d = '0;
        rden_d  = 1'b0;
        guard_d = guard_q;

        if (swch_edge) begin
            guard_d = GUARD_LOAD;
        end else if (guard_q != '0) begin
            guard_d = guard_q - GW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid && guard_open) begin
                    state_d        = ST_GRANT;
                    owner_d        = pick;
                    ptr_d          = (pick == LAST_IDX) ? '0 : pick + IW'(1);
                    hold_d         = '0;
                    grant_d[pick]  = 1'b1;
                end
            end
            ST_GRANT: begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
                if (!own_busy) begin
                    state_d = ST_RELEASE;
                end else if (hold_q >= HOLD_LIMIT) begin
                    state_d         = ST_RELEASE;
                    err_d[owner_q]  = 1'b1;
                    mask_d[owner_q] = 1'b1;
                end else begin
                    grant_d = grant_q;
                    wrd_d   = wrd_out[int'(owner_q) * DW +: DW];
                    waddr_d = wrd_addr[int'(owner_q) * AW +: AW];
                    wren_d  = wren[owner_q];
                    raddr_d = old_wrd_addr[int'(owner_q) * AW +: AW];
                    rden_d  = old_rd_en[owner_q];
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            guard_q <= '0;
            swch_q  <= 1'b0;
            mask_q  <= '0;
            err_q   <= '0;
            grant_q <= '0;
            wrd_q   <= '0;
            waddr_q <= '0;
            wren_q  <= 1'b0;
            raddr_q <= '0;
            rden_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            guard_q <= guard_d;
            swch_q  <= swch;
            mask_q  <= mask_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            wrd_q   <= wrd_d;
            waddr_q <= waddr_d;
            wren_q  <= wren_d;
            raddr_q <= raddr_d;
            rden_q  <= rden_d;
        end
    end

    assign grant             = grant_q;
    assign old_wrd           = comm_old_wrd;
    assign comm_wrd_out      = wrd_q;
    assign comm_wrd_addr     = waddr_q;
    assign comm_wren         = wren_q;
    assign comm_old_wrd_addr = raddr_q;
    assign comm_old_rd_en    = rden_q;
    assign timeout_err       = err_q;

endmodule

// File: tb/tb_lcb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcb_mem_arbiter
// Self-checking bench for lcb_mem_arbiter with default parameters.
// ---------------------------------------------------------------------------
module tb_lcb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  busy;
    logic [47:0] wrdOut;
    logic [39:0] wrdAddr;
    logic [3:0]  wren;
    logic [39:0] oldWrdAddr;
    logic [3:0]  oldRdEn;
    logic        swch;
    logic [11:0] commOldWrd;
    logic [3:0]  grant;
    logic [11:0] oldWrd;
    logic [11:0] commWrdOut;
    logic [9:0]  commWrdAddr;
    logic        commWren;
    logic [9:0]  commOldWrdAddr;
    logic        commOldRdEn;
    logic [3:0]  timeoutErr;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic [3:0]  busy;
        logic [3:0]  wren;
        logic [3:0]  rden;
        logic [9:0]  adr;
        logic [11:0] dat;
        logic [3:0]  expGrant;
        logic        expWren;
        logic [9:0]  expWaddr;
        logic [11:0] expWdat;
        logic        expRden;
        logic [9:0]  expRaddr;
    } vec_t;

    typedef struct {
        logic [3:0]  grant;
        logic        wren;
        logic [9:0]  waddr;
        logic [11:0] wdat;
        logic        rden;
        logic [9:0]  raddr;
    } exp_t;

    vec_t vecs[13];
    exp_t sbQueue[$];

    lcb_mem_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .busy              (busy),
        .wrd_out           (wrdOut),
        .wrd_addr          (wrdAddr),
        .wren              (wren),
        .old_wrd_addr      (oldWrdAddr),
        .old_rd_en         (oldRdEn),
        .swch              (swch),
        .comm_old_wrd      (commOldWrd),
        .grant             (grant),
        .old_wrd           (oldWrd),
        .comm_wrd_out      (commWrdOut),
        .comm_wrd_addr     (commWrdAddr),
        .comm_wren         (commWren),
        .comm_old_wrd_addr (commOldWrdAddr),
        .comm_old_rd_en    (commOldRdEn),
        .timeout_err       (timeoutErr)
    );

    // 100 MHz-style free-running clock; absolute rate is irrelevant here.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges; reports before terminating.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Requester 2 carries the test data; the others carry fixed distinct junk.
    task automatic applyStimulus(input logic [3:0] b, input logic [3:0] we,
                                 input logic [3:0] re, input logic [9:0] adr,
                                 input logic [11:0] dat);
        busy    = b;
        wren    = we;
        oldRdEn = re;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                wrdAddr[i*10 +: 10]    = adr;
                wrdOut[i*12 +: 12]     = dat;
                oldWrdAddr[i*10 +: 10] = adr ^ 10'h3FF;
            end else begin
                wrdAddr[i*10 +: 10]    = 10'h3F0 + 10'(i);
                wrdOut[i*12 +: 12]     = 12'hF00 + 12'(i);
                oldWrdAddr[i*10 +: 10] = 10'h200 + 10'(i);
            end
        end
    endtask

    task automatic waitForGrant(input string name, input int bound);
        int n = 0;
        while (grant == 4'b0000 && n < bound) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(grant != 4'b0000), 32'd1);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'h000, 12'h000);
        swch       = 1'b0;
        commOldWrd = 12'h000;
        tick();
        tick();
        checkOutput("rst.grant", 32'(grant), 32'h0);
        checkOutput("rst.wren", 32'(commWren), 32'h0);
        checkOutput("rst.err", 32'(timeoutErr), 32'h0);
        checkOutput("rst.waddr", 32'(commWrdAddr), 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        exp_t got;
        int   held;
        int   regrant;
        bit   released;
        logic [11:0] rnd;

        // busy, wren, rden, adr, dat | grant, wren, waddr, wdat, rden, raddr
        vecs[0]  = '{4'b0100, 4'b0000, 4'b0000, 10'h155, 12'hABC, 4'b0100, 1'b0, 10'h000, 12'h000, 1'b0, 10'h000};
        vecs[1]  = '{4'b0100, 4'b1111, 4'b0000, 10'h155, 12'hABC, 4'b0100, 1'b1, 10'h155, 12'hABC, 1'b0, 10'h2AA};
        vecs[2]  = '{4'b0100, 4'b1011, 4'b0100, 10'h2AA, 12'h123, 4'b0100, 1'b0, 10'h2AA, 12'h123, 1'b1, 10'h155};
        vecs[3]  = '{4'b0100, 4'b0000, 4'b1011, 10'h000, 12'h000, 4'b0100, 1'b0, 10'h000, 12'h000, 1'b0, 10'h3FF};
        vecs[4]  = '{4'b0000, 4'b1111, 4'b1111, 10'h155, 12'hABC, 4'b0000, 1'b0, 10'h000, 12'h000, 1'b0, 10'h000};
        vecs[5]  = '{4'b0000, 4'b1111, 4'b1111, 10'h155, 12'hABC, 4'b0000, 1'b0, 10'h000, 12'h000, 1'b0, 10'h000};
        vecs[6]  = '{4'b1010, 4'b1111, 4'b0000, 10'h155, 12'hABC, 4'b1000, 1'b0, 10'h000, 12'h000, 1'b0, 10'h000};
        vecs[7]  = '{4'b1010, 4'b1111, 4'b1111, 10'h155, 12'hABC, 4'b1000, 1'b1, 10'h3F3, 12'hF03, 1'b1, 10'h203};
        vecs[8]  = '{4'b0010, 4'b1111, 4'b1111, 10'h155, 12'hABC, 4'b0000, 1'b0, 10'h000, 12'h000, 1'b0, 10'h000};
        vecs[9]  = '{4'b0010, 4'b0000, 4'b0000, 10'h155, 12'hABC, 4'b0000, 1'b0, 10'h000, 12'h000, 1'b0, 10'h000};
        vecs[10] = '{4'b0010, 4'b0100, 4'b0000, 10'h155, 12'hABC, 4'b0010, 1'b0, 10'h000, 12'h000, 1'b0, 10'h000};
        vecs[11] = '{4'b0010, 4'b0010, 4'b0000, 10'h155, 12'hABC, 4'b0010, 1'b1, 10'h3F1, 12'hF01, 1'b0, 10'h201};
        vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 10'h155, 12'hABC, 4'b0000, 1'b0, 10'h000, 12'h000, 1'b0, 10'h000};

        // Table: shared-port mux, one-cycle latency, non-owner isolation.
        resetDut();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].busy, vecs[i].wren, vecs[i].rden, vecs[i].adr, vecs[i].dat);
            sbQueue.push_back('{vecs[i].expGrant, vecs[i].expWren, vecs[i].expWaddr,
                                vecs[i].expWdat, vecs[i].expRden, vecs[i].expRaddr});
            tick();
            got = sbQueue.pop_front();
            checkOutput($sformatf("vec%0d.grant", i), 32'(grant), 32'(got.grant));
            checkOutput($sformatf("vec%0d.wren", i), 32'(commWren), 32'(got.wren));
            checkOutput($sformatf("vec%0d.waddr", i), 32'(commWrdAddr), 32'(got.waddr));
            checkOutput($sformatf("vec%0d.wdat", i), 32'(commWrdOut), 32'(got.wdat));
            checkOutput($sformatf("vec%0d.rden", i), 32'(commOldRdEn), 32'(got.rden));
            checkOutput($sformatf("vec%0d.raddr", i), 32'(commOldWrdAddr), 32'(got.raddr));
        end

        // Read data is a combinational broadcast.
        for (int i = 0; i < 3; i++) begin
            rnd        = 12'($urandom);
            commOldWrd = rnd;
            #1;
            checkOutput($sformatf("oldWrd%0d", i), 32'(oldWrd), 32'(rnd));
        end

        // Single requester: grant one cycle later, zero after busy falls.
        resetDut();
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 10'h000, 12'h000);
        tick();
        checkOutput("single.latency", 32'(grant), 32'h1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("single.held", 32'(grant), 32'h1);
        busy = 4'b0000;
        tick();
        checkOutput("single.gap", 32'(grant), 32'h0);
        busy = 4'b0001;
        waitForGrant("single.regrant", 4);

        // All busy, each owner drops after 3 cycles: order 0,1,2,3,0.
        resetDut();
        busy = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            waitForGrant($sformatf("rr%0d.wait", r), 6);
            checkOutput($sformatf("rr%0d.order", r), 32'(grant), 32'(4'b0001 << (r % 4)));
            tick();
            tick();
            busy = busy & ~grant;
            tick();
            checkOutput($sformatf("rr%0d.gap", r), 32'(grant), 32'h0);
            busy = 4'b1111;
        end

        // Buffer switch in IDLE with a pending request: guard wins.
        resetDut();
        busy = 4'b0100;
        swch = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checkOutput($sformatf("guard.block%0d", i), 32'(grant), 32'h0);
        end
        tick();
        checkOutput("guard.grant", 32'(grant), 32'h4);
        swch = 1'b0;
        tick();
        tick();
        checkOutput("guard.noAbort", 32'(grant), 32'h4);

        // Busy falls exactly on the timeout cycle: normal release, no flag.
        resetDut();
        busy = 4'b0100;
        tick();
        held = (grant == 4'b0100) ? 1 : 0;
        for (int n = 1; n < 1023; n++) begin
            tick();
            if (grant == 4'b0100) held++;
        end
        checkOutput("fallTo.held", 32'(held), 32'd1023);
        busy = 4'b0000;
        tick();
        checkOutput("fallTo.grant", 32'(grant), 32'h0);
        checkOutput("fallTo.err", 32'(timeoutErr), 32'h0);

        // Requester 1 holds busy for 1100 cycles: timeout at 1023, masked.
        resetDut();
        busy     = 4'b0010;
        held     = 0;
        regrant  = 0;
        released = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            tick();
            if (grant == 4'b0010) begin
                if (released) regrant++;
                else held++;
            end else if (held > 0) begin
                released = 1'b1;
            end
        end
        checkOutput("timeout.held", 32'(held), 32'd1023);
        checkOutput("timeout.regrant", 32'(regrant), 32'd0);
        checkOutput("timeout.err", 32'(timeoutErr), 32'h2);
        busy = 4'b0000;
        tick();
        tick();
        busy = 4'b0010;
        waitForGrant("timeout.unmask", 6);
        checkOutput("timeout.unmaskOwner", 32'(grant), 32'h2);
        checkOutput("timeout.sticky", 32'(timeoutErr), 32'h2);

        // Reset mid-grant clears outputs without a clock edge.
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 10'h000, 12'h000);
        tick();
        tick();
        tick();
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 10'h155, 12'hABC);
        waitForGrant("midRst.wait", 6);
        tick();
        checkOutput("midRst.wrenBefore", 32'(commWren), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRst.grant", 32'(grant), 32'h0);
        checkOutput("midRst.wren", 32'(commWren), 32'h0);
        checkOutput("midRst.err", 32'(timeoutErr), 32'h0);
        tick();
        reset = 1'b0;
        applyStimulus(4'b1010, 4'b0000, 4'b0000, 10'h000, 12'h000);
        waitForGrant("midRst.regrantWait", 6);
        checkOutput("midRst.rrStart", 32'(grant), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/lcb_mem_arbiter.md
LCB_MEM_ARBITER -- requirements
Module: lcb_mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of LCB requesters.
REQ-002 Parameter AW, default 10: group-buffer address width.
REQ-003 Parameter DW, default 12: Orbita word width.
REQ-004 Parameter TIMEOUT, default 1023: maximum clk cycles one grant may be held.
REQ-005 Parameter SWAP_GUARD, default 8: grant-blocking cycles after a buffer switch.
REQ-006 clk  in  1  system clock, 80 MHz. One clock; reset is asynchronous and active-high.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 busy  in  N_REQ  per-requester memory request; held high for the whole transaction.
REQ-009 wrd_out  in  N_REQ*DW  per-requester write data, flattened, requester 0 in the LSBs.
REQ-010 wrd_addr  in  N_REQ*AW  per-requester write address, flattened.
REQ-011 wren  in  N_REQ  per-requester write enable.
REQ-012 old_wrd_addr  in  N_REQ*AW  per-requester read address, flattened.
REQ-013 old_rd_en  in  N_REQ  per-requester read enable.
REQ-014 swch  in  1  ping-pong buffer selector from the frame former.
REQ-015 comm_old_wrd  in  DW  read data from the shared memory port.
REQ-016 grant  out  N_REQ  one-hot ownership of the shared port.
REQ-017 old_wrd  out  DW  comm_old_wrd broadcast to all requesters.
REQ-018 comm_wrd_out, comm_wrd_addr, comm_wren  out  DW/AW/1  shared write port.
REQ-019 comm_old_wrd_addr, comm_old_rd_en  out  AW/1  shared read port.
REQ-020 timeout_err  out  N_REQ  sticky per-requester timeout flags.

Function
REQ-021 FSM states: IDLE, GRANT, RELEASE.
REQ-022 IDLE -> GRANT when any unmasked busy bit is high and the swap guard counter is zero; grant goes high on the next clk edge.
REQ-023 Winner selection is round-robin, searching from (last owner + 1) mod N_REQ; after reset the search starts at requester 0.
REQ-024 GRANT -> RELEASE when the owner's busy falls, or when the hold counter reaches TIMEOUT.
REQ-025 RELEASE -> IDLE after exactly one cycle; grant is all-zero in RELEASE, so ownership always has a one-cycle gap.
REQ-026 Shared-port outputs are registered from the owner's inputs: 1-cycle latency from the owner's wren/old_rd_en to comm_wren/comm_old_rd_en.
REQ-027 Outside GRANT, comm_wren = 0, comm_old_rd_en = 0, and addresses/data = 0.
REQ-028 Inputs from non-owners are ignored.
REQ-029 old_wrd = comm_old_wrd, combinational; requesters consume it only while granted.
REQ-030 Hold counter: cleared on entry to GRANT, +1 per GRANT cycle, saturating at TIMEOUT.
REQ-031 On timeout:
  - set timeout_err[owner];
  - mask that requester until its busy is observed low;
  - timeout_err stays set until reset.
REQ-032 Any swch edge (either direction) loads the guard counter with SWAP_GUARD; the counter decrements to 0 each cycle.
REQ-033 A grant in progress is not aborted by a swch edge; only new grants are blocked.
REQ-034 Simultaneous busy falling and TIMEOUT: treated as normal release, no error flag.
REQ-035 Simultaneous swch edge and IDLE->GRANT decision: the guard wins, no grant is issued.
REQ-036 swch is sampled into one register for edge detection (same clock domain).

Reset
REQ-037 On reset, all outputs go to 0, the FSM goes to IDLE, and the round-robin pointer, counters, mask and swch history go to 0, asynchronously.
REQ-038 Reset asserted mid-GRANT drops grant and comm_wren within the reset assertion (not clk-gated).

Structure
REQ-039 State encoding and default widths go in shared package ffm_pkg.
REQ-040 A single sub-module rr_pick (combinational round-robin pick) is used.
REQ-041 The FSM, counters and registered mux are in lcb_mem_arbiter.

Verification
REQ-042 Directed scenarios the bench must cover:
  - busy = 0001 for 5 cycles -> grant = 0001 one cycle later, then a 1-cycle zero gap after busy falls.
  - busy = 1111 held, each requester dropping after 3 cycles -> grants in order 0, 1, 2, 3, 0.
  - Owner 2 writes addr 0x155, data 0xABC -> comm_wren = 1, comm_wrd_addr = 0x155, comm_wrd_out = 0xABC exactly 1 cycle later; other requesters' wren ignored.
  - busy[1] held 1100 cycles -> release at cycle 1023, timeout_err = 0010, requester 1 not re-granted until busy[1] goes low.
  - swch toggle with busy = 0100 in IDLE -> no grant for 8 cycles, grant = 0100 on cycle 9.
  - reset pulse mid-GRANT -> grant, comm_wren and timeout_err = 0 immediately; next grant starts search at requester 0.
